// File: rtl/dyn_clk_gen.sv
// dyn_clk_gen
//   Runtime-reconfigurable multi-channel clock generator. Each of the
//   NUM_CLOCKS outputs is refclk divided by an integer ratio, with its own
//   high time and phase offset (all in refclk cycles). Settings are written
//   into per-channel shadow registers over a valid/ready port; a write
//   carrying cfg_apply copies every shadow into the active set and restarts
//   all channels from a common alignment point.
//
// Ports
//   refclk     : sole clock, rising edge
//   rst        : synchronous reset, active low
//   cfg_valid  : configuration request
//   cfg_ready  : configuration port can accept (SETTLE / LOCKED only)
//   cfg_chan   : target channel
//   cfg_div    : divide ratio (output period in refclk cycles)
//   cfg_high   : high cycles per period
//   cfg_phase  : start delay after alignment, in refclk cycles
//   cfg_apply  : restart all channels with shadow settings after this write
//   cfg_err    : one-cycle pulse, previous request was rejected
//   outclk     : generated clocks, registered
//   locked     : outputs aligned and stable
module dyn_clk_gen #(
    parameter int NUM_CLOCKS    = 2,
    parameter int CNT_W         = 16,
    parameter int LOCK_CYCLES   = 16,
    parameter int DEFAULT_DIV   = 2,
    parameter int DEFAULT_HIGH  = 1,
    parameter int DEFAULT_PHASE = 0,
    localparam int CH_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_chan,
    input  logic [CNT_W-1:0]      cfg_div,
    input  logic [CNT_W-1:0]      cfg_high,
    input  logic [CNT_W-1:0]      cfg_phase,
    input  logic                  cfg_apply,
    output logic                  cfg_err,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic                  locked
);

    localparam int LK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_ALIGN  = 2'd1,
        S_SETTLE = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   ready_q, ready_d;
    logic   locked_q, locked_d;
    logic   err_q, err_d;

    logic [NUM_CLOCKS-1:0][CNT_W-1:0] sdiv_q, sdiv_d, shigh_q, shigh_d, sph_q, sph_d;
    logic [NUM_CLOCKS-1:0][CNT_W-1:0] adiv_q, adiv_d, ahigh_q, ahigh_d, aph_q, aph_d;
    logic [NUM_CLOCKS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CLOCKS-1:0]            run_q, run_d;
    logic [NUM_CLOCKS-1:0]            outclk_q, outclk_d;

    logic [CNT_W-1:0] acnt_q, acnt_d;
    logic [LK_W-1:0]  scnt_q, scnt_d;
    logic [CNT_W-1:0] max_ph;

    logic xfer, req_bad, wr_ok, restart, enter_align;

    // Request decode: a transfer that fails validation only raises cfg_err.
    always_comb begin
        xfer    = cfg_valid && ready_q;
        req_bad = (int'(cfg_chan) >= NUM_CLOCKS) ||
                  (cfg_div < CNT_W'(2)) ||
                  (cfg_high == '0) ||
                  (cfg_high >= cfg_div) ||
                  (cfg_phase >= cfg_div);
        wr_ok   = xfer && !req_bad;
        restart = wr_ok && cfg_apply;
    end

    // Latest-starting channel decides when alignment is finished.
    always_comb begin
        max_ph = '0;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (aph_q[i] > max_ph) max_ph = aph_q[i];
        end
    end

    always_comb begin
        sdiv_d  = sdiv_q;
        shigh_d = shigh_q;
        sph_d   = sph_q;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (wr_ok && (cfg_chan == CH_W'(i))) begin
                sdiv_d[i]  = cfg_div;
                shigh_d[i] = cfg_high;
                sph_d[i]   = cfg_phase;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        enter_align = 1'b0;
        case (state_q)
            S_RESET:  enter_align = 1'b1;
            S_ALIGN:  if (acnt_q == max_ph) state_d = S_SETTLE;
            S_SETTLE: begin
                if (restart)                 enter_align = 1'b1;
                else if (scnt_q == LK_LAST)  state_d = S_LOCKED;
            end
            S_LOCKED: if (restart) enter_align = 1'b1;
            default:  enter_align = 1'b1;
        endcase
        if (enter_align) state_d = S_ALIGN;

        ready_d  = (state_d == S_SETTLE) || (state_d == S_LOCKED);
        locked_d = (state_q == S_LOCKED) && !restart;
        err_d    = xfer && req_bad;

        // Active set is loaded from the shadow including this cycle's write.
        adiv_d  = enter_align ? sdiv_d  : adiv_q;
        ahigh_d = enter_align ? shigh_d : ahigh_q;
        aph_d   = enter_align ? sph_d   : aph_q;

        acnt_d = enter_align ? '0 : acnt_q + CNT_W'(1);
        scnt_d = (state_q == S_SETTLE) ? scnt_q + LK_W'(1) : '0;
    end

    // Channel counters. The output is decoded from the next count so that
    // outclk rises on the same edge that starts the channel.
    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        outclk_d = '0;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (enter_align) begin
                run_d[i] = 1'b0;
            end else if ((state_q == S_ALIGN) && (acnt_q == aph_q[i])) begin
                run_d[i] = 1'b1;
                cnt_d[i] = '0;
            end else if (run_q[i]) begin
                cnt_d[i] = (cnt_q[i] == adiv_q[i] - CNT_W'(1)) ? '0 : cnt_q[i] + CNT_W'(1);
            end
            outclk_d[i] = run_d[i] && (cnt_d[i] < ahigh_q[i]);
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            state_q  <= S_RESET;
            ready_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            run_q    <= '0;
            outclk_q <= '0;
            sdiv_q   <= {NUM_CLOCKS{CNT_W'(DEFAULT_DIV)}};
            shigh_q  <= {NUM_CLOCKS{CNT_W'(DEFAULT_HIGH)}};
            sph_q    <= {NUM_CLOCKS{CNT_W'(DEFAULT_PHASE)}};
            adiv_q   <= {NUM_CLOCKS{CNT_W'(DEFAULT_DIV)}};
            ahigh_q  <= {NUM_CLOCKS{CNT_W'(DEFAULT_HIGH)}};
            aph_q    <= {NUM_CLOCKS{CNT_W'(DEFAULT_PHASE)}};
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            run_q    <= run_d;
            outclk_q <= outclk_d;
            sdiv_q   <= sdiv_d;
            shigh_q  <= shigh_d;
            sph_q    <= sph_d;
            adiv_q   <= adiv_d;
            ahigh_q  <= ahigh_d;
            aph_q    <= aph_d;
        end
    end

    // Counters are always reloaded before use, so they carry no reset.
    always_ff @(posedge refclk) begin
        cnt_q  <= cnt_d;
        acnt_q <= acnt_d;
        scnt_q <= scnt_d;
    end

    assign cfg_ready = ready_q & rst;
    assign cfg_err   = err_q;
    assign outclk    = outclk_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_dyn_clk_gen.sv
module tb_dyn_clk_gen;

    localparam int NC = 3;
    localparam int LC = 16;
    localparam int CW = 16;

    logic          refclk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_chan = '0;
    logic [CW-1:0] cfg_div = '0;
    logic [CW-1:0] cfg_high = '0;
    logic [CW-1:0] cfg_phase = '0;
    logic          cfg_apply = 1'b0;
    logic          cfg_err;
    logic [NC-1:0] outclk;
    logic          locked;

    dyn_clk_gen #(.NUM_CLOCKS(NC), .CNT_W(CW), .LOCK_CYCLES(LC),
                  .DEFAULT_DIV(2), .DEFAULT_HIGH(1), .DEFAULT_PHASE(0)) dut (
        .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_high(cfg_high),
        .cfg_phase(cfg_phase), .cfg_apply(cfg_apply), .cfg_err(cfg_err),
        .outclk(outclk), .locked(locked)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic [1:0] chan;
        int         div;
        int         high;
        int         phase;
        bit         apply;
        bit         err;
    } vec_t;

    vec_t tbl[12];

    int n_vec = 0;
    int n_err = 0;

    // Timeline model: outputs are a function of the cycle index relative to
    // the last alignment start t0 and the active settings.
    int ecnt = 0;
    int t0 = 0;
    bit inrst = 1'b1;
    bit err_e = 1'b0;
    int sdiv[NC], shigh[NC], sph[NC];
    int adiv[NC], ahigh[NC], aph[NC];

    int n, r0, r0b, r1;
    bit p0, p1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h want %0h", name, ecnt, act, exp);
        end
    endtask

    function automatic int maxp();
        int m = 0;
        for (int i = 0; i < NC; i++) if (aph[i] > m) m = aph[i];
        return m;
    endfunction

    function automatic bit rdy_exp();
        return !inrst && (ecnt >= t0 + maxp() + 1);
    endfunction

    task automatic model_edge();
        bit xfer, bad;
        if (!rst) begin
            inrst = 1'b1;
            err_e = 1'b0;
            for (int i = 0; i < NC; i++) begin
                sdiv[i] = 2; shigh[i] = 1; sph[i] = 0;
            end
        end else if (inrst) begin
            inrst = 1'b0;
            err_e = 1'b0;
            t0 = ecnt + 1;
            for (int i = 0; i < NC; i++) begin
                adiv[i] = sdiv[i]; ahigh[i] = shigh[i]; aph[i] = sph[i];
            end
        end else begin
            xfer = cfg_valid && rdy_exp();
            bad = (int'(cfg_chan) >= NC) || (cfg_div < 2) || (cfg_high == 0) ||
                  (cfg_high >= cfg_div) || (cfg_phase >= cfg_div);
            err_e = xfer && bad;
            if (xfer && !bad) begin
                sdiv[cfg_chan] = int'(cfg_div);
                shigh[cfg_chan] = int'(cfg_high);
                sph[cfg_chan] = int'(cfg_phase);
                if (cfg_apply) begin
                    t0 = ecnt + 1;
                    for (int i = 0; i < NC; i++) begin
                        adiv[i] = sdiv[i]; ahigh[i] = shigh[i]; aph[i] = sph[i];
                    end
                end
            end
        end
        ecnt++;
    endtask

    task automatic check_cycle();
        int e = 0;
        int k;
        if (!inrst) begin
            for (int i = 0; i < NC; i++) begin
                k = ecnt - t0 - aph[i] - 1;
                if (k >= 0 && (k % adiv[i]) < ahigh[i]) e |= (1 << (i + 3));
            end
            if (ecnt >= t0 + maxp() + LC + 2) e |= 4;
            if (rst && rdy_exp()) e |= 2;
            if (err_e) e |= 1;
        end
        chk("cycle{outclk,locked,ready,err}", int'({outclk, locked, cfg_ready, cfg_err}), e);
    endtask

    task automatic tick();
        @(posedge refclk);
        model_edge();
        @(negedge refclk);
        check_cycle();
    endtask

    task automatic drive(input vec_t v);
        cfg_valid = 1'b1;
        cfg_chan  = v.chan;
        cfg_div   = CW'(v.div);
        cfg_high  = CW'(v.high);
        cfg_phase = CW'(v.phase);
        cfg_apply = v.apply;
    endtask

    task automatic run_group(input int a, input int b);
        for (int k = a; k <= b; k++) begin
            drive(tbl[k]);
            tick();
            chk($sformatf("vec%0d_err", k), int'(cfg_err), int'(tbl[k].err));
        end
        cfg_valid = 1'b0;
        cfg_apply = 1'b0;
    endtask

    task automatic wait_lock(output int cnt);
        cnt = 0;
        while (!locked && cnt < 300) begin
            tick();
            cnt++;
        end
        chk("lock_wait", int'(locked), 1);
    endtask

    initial begin
        tbl[0]  = '{2'd0, 5, 2, 0, 1'b0, 1'b0};
        tbl[1]  = '{2'd1, 5, 2, 3, 1'b1, 1'b0};
        tbl[2]  = '{2'd0, 1, 1, 0, 1'b0, 1'b1};
        tbl[3]  = '{2'd0, 4, 4, 0, 1'b0, 1'b1};
        tbl[4]  = '{2'd0, 6, 1, 6, 1'b0, 1'b1};
        tbl[5]  = '{2'd3, 5, 2, 0, 1'b0, 1'b1};
        tbl[6]  = '{2'd1, 5, 0, 0, 1'b1, 1'b1};
        tbl[7]  = '{2'd2, 4, 1, 4, 1'b1, 1'b1};
        tbl[8]  = '{2'd0, 4, 1, 0, 1'b0, 1'b0};
        tbl[9]  = '{2'd1, 6, 3, 2, 1'b0, 1'b0};
        tbl[10] = '{2'd2, 3, 2, 1, 1'b0, 1'b0};
        tbl[11] = '{2'd0, 8, 5, 7, 1'b1, 1'b0};

        // Reset state
        repeat (3) tick();
        chk("rst_outclk", int'(outclk), 0);
        chk("rst_ready", int'(cfg_ready), 0);
        chk("rst_locked", int'(locked), 0);

        // Release: defaults, locked on edge 1+1+16+1
        rst = 1'b1;
        wait_lock(n);
        chk("lock_latency", n, 19);
        repeat (4) tick();

        // ch0 / ch1 reprogram with 3-cycle skew
        run_group(0, 1);
        chk("apply_drop", int'(locked), 0);
        r0 = -100; r0b = -100; r1 = -100;
        p0 = outclk[0]; p1 = outclk[1];
        for (int j = 1; j <= 15; j++) begin
            tick();
            if (outclk[0] && !p0) begin
                if (r0 < 0) r0 = j;
                else if (r0b < 0) r0b = j;
            end
            if (outclk[1] && !p1 && r1 < 0) r1 = j;
            p0 = outclk[0]; p1 = outclk[1];
        end
        chk("ch0_first_rise", r0, 1);
        chk("ch1_skew", r1 - r0, 3);
        chk("ch0_period", r0b - r0, 5);
        wait_lock(n);

        // Rejected writes leave everything running
        run_group(2, 7);
        tick();
        chk("err_cleared", int'(cfg_err), 0);
        chk("still_locked", int'(locked), 1);
        repeat (6) tick();

        // Apply during SETTLE restarts alignment
        drive('{2'd2, 7, 3, 4, 1'b1, 1'b0});
        tick();
        cfg_valid = 1'b0;
        n = 0;
        while (!cfg_ready && n < 50) begin
            tick();
            n++;
        end
        chk("reach_settle", int'(cfg_ready), 1);
        drive('{2'd0, 3, 1, 2, 1'b1, 1'b0});
        tick();
        chk("settle_restart_out", int'(outclk), 0);
        n = 0;
        while (!cfg_ready && n < 30) begin
            n++;
            tick();
        end
        cfg_valid = 1'b0;
        cfg_apply = 1'b0;
        chk("align_ready_low_cycles", n, 5);
        chk("settle_locked_low", int'(locked), 0);
        wait_lock(n);
        chk("relock_latency", n, LC + 1);
        repeat (10) tick();

        // Reset in LOCKED with a concurrent apply write
        rst = 1'b0;
        drive('{2'd0, 9, 4, 1, 1'b1, 1'b0});
        tick();
        chk("midrst_outclk", int'(outclk), 0);
        chk("midrst_locked", int'(locked), 0);
        cfg_valid = 1'b0;
        cfg_apply = 1'b0;
        tick();
        rst = 1'b1;
        wait_lock(n);
        chk("midrst_relock", n, 19);
        repeat (4) tick();

        // Back-to-back writes, apply on the last
        run_group(8, 11);
        r0 = -100;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (outclk[0] && r0 < 0) r0 = j;
        end
        chk("b2b_ch0_rise", r0, 8);
        wait_lock(n);
        repeat (30) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
